// File: rtl/pc_seq.sv
// Program-counter sequencer: load, increment, relative branch,
// and call/return through a small return-address stack.
module pc_seq #(
  parameter int unsigned WIDTH       = 5,
  parameter int unsigned STACK_DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  localparam int unsigned SPW = $clog2(STACK_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld_pc,
  input  logic             inc_pc,
  input  logic             br_pc,
  input  logic             call_pc,
  input  logic             ret_pc,
  input  logic             err_clr,
  input  logic [WIDTH-1:0] pc_in,
  input  logic [WIDTH-1:0] br_off,
  output logic [WIDTH-1:0] pc_out,
  output logic [SPW-1:0]   sp,
  output logic             stk_empty,
  output logic             stk_full,
  output logic             err_ovf,
  output logic             err_unf
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [SPW-1:0]   sp_q, sp_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] stk_q [STACK_DEPTH];
  logic [WIDTH-1:0] top;
  logic [WIDTH-1:0] ret_addr;
  logic             push;
  logic             empty, full;

  assign empty    = (sp_q == '0);
  assign full     = (sp_q == SPW'(STACK_DEPTH));
  assign ret_addr = pc_q + WIDTH'(1);

  always_comb begin
    top = '0;
    for (int i = 0; i < STACK_DEPTH; i++)
      if (sp_q == SPW'(i + 1)) top = stk_q[i];
  end

  always_comb begin
    pc_d  = pc_q;
    sp_d  = sp_q;
    push  = 1'b0;
    ovf_d = err_clr ? 1'b0 : ovf_q;
    unf_d = err_clr ? 1'b0 : unf_q;
    priority case (1'b1)
      ret_pc: begin
        if (empty) begin
          unf_d = 1'b1;
        end else begin
          pc_d = top;
          sp_d = sp_q - SPW'(1);
        end
      end
      call_pc: begin
        if (full) begin
          ovf_d = 1'b1;
        end else begin
          push = 1'b1;
          pc_d = pc_in;
          sp_d = sp_q + SPW'(1);
        end
      end
      ld_pc:  pc_d = pc_in;
      br_pc:  pc_d = pc_q + br_off;
      inc_pc: pc_d = ret_addr;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= RESET_VEC;
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Stack storage needs no reset; sp alone defines which entries are live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < STACK_DEPTH; i++)
      if (push && !reset && sp_q == SPW'(i)) stk_q[i] <= ret_addr;
  end

  assign pc_out    = pc_q;
  assign sp        = sp_q;
  assign stk_empty = empty;
  assign stk_full  = full;
  assign err_ovf   = ovf_q;
  assign err_unf   = unf_q;

endmodule

// File: tb/tb_pc_seq.sv
// Directed self-checking bench for pc_seq
// (WIDTH=5, STACK_DEPTH=4, RESET_VEC=0).
module tb_pc_seq;
  logic       clk = 1'b0;
  logic       reset, ld_pc, inc_pc, br_pc, call_pc, ret_pc, err_clr;
  logic [4:0] pc_in, br_off, pc_out;
  logic [2:0] sp;
  logic       stk_empty, stk_full, err_ovf, err_unf;
  int checks = 0;
  int failures = 0;

  pc_seq #(.WIDTH(5), .STACK_DEPTH(4), .RESET_VEC(5'd0)) dut (
    .clk(clk), .reset(reset), .ld_pc(ld_pc), .inc_pc(inc_pc),
    .br_pc(br_pc), .call_pc(call_pc), .ret_pc(ret_pc),
    .err_clr(err_clr), .pc_in(pc_in), .br_off(br_off),
    .pc_out(pc_out), .sp(sp), .stk_empty(stk_empty),
    .stk_full(stk_full), .err_ovf(err_ovf), .err_unf(err_unf)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    ld_pc = 0; inc_pc = 0; br_pc = 0; call_pc = 0;
    ret_pc = 0; err_clr = 0;
  endtask

  task automatic do_ld(input logic [4:0] v);
    pc_in = v; ld_pc = 1; tick(); idle();
  endtask

  task automatic do_call(input logic [4:0] v);
    pc_in = v; call_pc = 1; tick(); idle();
  endtask

  task automatic do_ret;
    ret_pc = 1; tick(); idle();
  endtask

  task automatic test_reset;
    idle(); pc_in = 0; br_off = 0;
    reset = 1; tick(); tick();
    reset = 0; #30;
    checks++;
    if (pc_out !== 5'd0 || sp !== 3'd0) begin
      failures++;
      $display("FAIL reset_pc_sp: pc=%0d sp=%0d exp 0 0", pc_out, sp);
    end
    checks++;
    if ({stk_empty, stk_full, err_ovf, err_unf} !== 4'b1000) begin
      failures++;
      $display("FAIL reset_flags: got %b exp 1000",
               {stk_empty, stk_full, err_ovf, err_unf});
    end
  endtask

  task automatic test_ld_inc;
    do_ld(5'b10010);
    checks++;
    if (pc_out !== 5'd18) begin
      failures++; $display("FAIL ld: pc=%0d exp 18", pc_out);
    end
    for (int i = 0; i < 13; i++) begin
      inc_pc = 1; tick();
    end
    idle();
    checks++;
    if (pc_out !== 5'd31) begin
      failures++; $display("FAIL inc13: pc=%0d exp 31", pc_out);
    end
    inc_pc = 1; tick(); idle();
    checks++;
    if (pc_out !== 5'd0) begin
      failures++; $display("FAIL inc_wrap: pc=%0d exp 0", pc_out);
    end
    tick(); tick();
    checks++;
    if (pc_out !== 5'd0) begin
      failures++; $display("FAIL hold: pc=%0d exp 0", pc_out);
    end
  endtask

  task automatic test_branch;
    do_ld(5'd3);
    br_off = 5'b11100; br_pc = 1; tick(); idle();
    checks++;
    if (pc_out !== 5'd31) begin
      failures++; $display("FAIL br_neg: pc=%0d exp 31", pc_out);
    end
    br_off = 5'b00110; br_pc = 1; tick(); idle();
    checks++;
    if (pc_out !== 5'd5) begin
      failures++; $display("FAIL br_pos_wrap: pc=%0d exp 5", pc_out);
    end
    do_ld(5'd1);
    br_off = 5'b11110; br_pc = 1; tick(); idle();
    checks++;
    if (pc_out !== 5'd31) begin
      failures++; $display("FAIL br_1m2: pc=%0d exp 31", pc_out);
    end
    pc_in = 5'd12; ld_pc = 1; inc_pc = 1; br_pc = 1; tick(); idle();
    checks++;
    if (pc_out !== 5'd12) begin
      failures++; $display("FAIL ld_prio: pc=%0d exp 12", pc_out);
    end
  endtask

  task automatic test_call_ret;
    logic [4:0] exp_pop [4];
    exp_pop[0] = 5'd27; exp_pop[1] = 5'd26;
    exp_pop[2] = 5'd21; exp_pop[3] = 5'd11;
    do_ld(5'd10);
    do_call(5'd20);
    checks++;
    if (pc_out !== 5'd20 || sp !== 3'd1 || stk_empty !== 1'b0) begin
      failures++;
      $display("FAIL call1: pc=%0d sp=%0d empty=%b exp 20 1 0",
               pc_out, sp, stk_empty);
    end
    do_call(5'd25);
    do_call(5'd26);
    do_call(5'd27);
    checks++;
    if (pc_out !== 5'd27 || sp !== 3'd4 || stk_full !== 1'b1) begin
      failures++;
      $display("FAIL call_full: pc=%0d sp=%0d full=%b exp 27 4 1",
               pc_out, sp, stk_full);
    end
    do_call(5'd9);
    checks++;
    if (pc_out !== 5'd27 || sp !== 3'd4 || err_ovf !== 1'b1) begin
      failures++;
      $display("FAIL call_ovf: pc=%0d sp=%0d ovf=%b exp 27 4 1",
               pc_out, sp, err_ovf);
    end
    for (int i = 0; i < 4; i++) begin
      do_ret();
      checks++;
      if (pc_out !== exp_pop[i] || sp !== 3'(3 - i)) begin
        failures++;
        $display("FAIL pop%0d: pc=%0d sp=%0d exp %0d %0d",
                 i, pc_out, sp, exp_pop[i], 3 - i);
      end
    end
    checks++;
    if (stk_empty !== 1'b1 || err_ovf !== 1'b1) begin
      failures++;
      $display("FAIL after_pops: empty=%b ovf=%b exp 1 1", stk_empty, err_ovf);
    end
    err_clr = 1; tick(); idle();
    checks++;
    if (err_ovf !== 1'b0) begin
      failures++; $display("FAIL ovf_clr: ovf=%b exp 0", err_ovf);
    end
    do_ld(5'd31);
    do_call(5'd4);
    do_ret();
    checks++;
    if (pc_out !== 5'd0 || sp !== 3'd0) begin
      failures++;
      $display("FAIL call_wrap: pc=%0d sp=%0d exp 0 0", pc_out, sp);
    end
    do_ld(5'd1);
    do_call(5'd5);
    pc_in = 5'd17; ret_pc = 1; call_pc = 1; ld_pc = 1; tick(); idle();
    checks++;
    if (pc_out !== 5'd2 || sp !== 3'd0) begin
      failures++;
      $display("FAIL ret_prio: pc=%0d sp=%0d exp 2 0", pc_out, sp);
    end
  endtask

  task automatic test_underflow;
    do_ld(5'd7);
    do_ret();
    checks++;
    if (pc_out !== 5'd7 || sp !== 3'd0 || err_unf !== 1'b1) begin
      failures++;
      $display("FAIL unf: pc=%0d sp=%0d unf=%b exp 7 0 1", pc_out, sp, err_unf);
    end
    err_clr = 1; tick(); idle();
    checks++;
    if (err_unf !== 1'b0) begin
      failures++; $display("FAIL unf_clr: unf=%b exp 0", err_unf);
    end
    ret_pc = 1; err_clr = 1; tick(); idle();
    checks++;
    if (err_unf !== 1'b1 || pc_out !== 5'd7) begin
      failures++;
      $display("FAIL set_wins: unf=%b pc=%0d exp 1 7", err_unf, pc_out);
    end
    err_clr = 1; tick(); idle();
  endtask

  task automatic test_mid_reset;
    do_ld(5'd2);
    do_call(5'd5);
    do_call(5'd8);
    pc_in = 5'd15; call_pc = 1;
    @(negedge clk); #2;
    reset = 1; #1;
    checks++;
    if (pc_out !== 5'd0 || sp !== 3'd0 || stk_empty !== 1'b1) begin
      failures++;
      $display("FAIL async_rst: pc=%0d sp=%0d empty=%b exp 0 0 1",
               pc_out, sp, stk_empty);
    end
    tick();
    reset = 0; idle(); tick();
    checks++;
    if (pc_out !== 5'd0 || sp !== 3'd0) begin
      failures++;
      $display("FAIL rst_hold: pc=%0d sp=%0d exp 0 0", pc_out, sp);
    end
    do_ret();
    checks++;
    if (pc_out !== 5'd0 || err_unf !== 1'b1) begin
      failures++;
      $display("FAIL post_rst_ret: pc=%0d unf=%b exp 0 1", pc_out, err_unf);
    end
    inc_pc = 1; tick(); idle();
    checks++;
    if (pc_out !== 5'd1) begin
      failures++; $display("FAIL post_rst_inc: pc=%0d exp 1", pc_out);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1;
    test_reset();
    test_ld_inc();
    test_branch();
    test_call_ret();
    test_underflow();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
